// File: rtl/multicycle_control_unit.sv
// Multi-cycle sequencer for the 16-bit single-issue datapath: owns PC and IR,
// fetches over a req/valid handshake and drives datapath controls per state.
module multicycle_control_unit #(
   parameter int                  PC_WIDTH = 16,
   parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
   input  logic                Clock,
   input  logic                Reset,
   input  logic                Run,
   output logic                InstrReq,
   output logic [PC_WIDTH-1:0] InstrAddr,
   input  logic                InstrValid,
   input  logic [15:0]         InstrIn,
   output logic [15:0]         Instruction,
   input  logic                Zero,
   input  logic                MemReady,
   output logic                RegDest,
   output logic                ALUSrc,
   output logic                MemToReg,
   output logic                RegWrite,
   output logic                MemRead,
   output logic                MemWrite,
   output logic                Branch,
   output logic [1:0]          AluOp,
   output logic                Halted
);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
   } state_t;

   localparam logic [2:0] OP_R    = 3'b000;
   localparam logic [2:0] OP_ADDI = 3'b001;
   localparam logic [2:0] OP_LW   = 3'b010;
   localparam logic [2:0] OP_SW   = 3'b011;
   localparam logic [2:0] OP_BEQ  = 3'b100;
   localparam logic [2:0] OP_BNE  = 3'b101;
   localparam logic [2:0] OP_J    = 3'b110;
   localparam logic [2:0] OP_HALT = 3'b111;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;

   localparam logic [PC_WIDTH-1:0] PC_ONE = {{(PC_WIDTH-1){1'b0}}, 1'b1};

   state_t              state_q;
   logic [PC_WIDTH-1:0] pc_q;
   logic [15:0]         ir_q;

   logic [2:0]          op;
   logic [PC_WIDTH-1:0] imm_sext;
   logic                branch_taken;

   assign op           = ir_q[15:13];
   assign imm_sext     = {{(PC_WIDTH-7){ir_q[6]}}, ir_q[6:0]};
   assign branch_taken = ((op == OP_BEQ) && Zero) || ((op == OP_BNE) && !Zero);

   assign InstrAddr   = pc_q;
   assign Instruction = ir_q;

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q <= S_IDLE;
         pc_q    <= RESET_PC;
         ir_q    <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (Run) state_q <= S_FETCH;
            end
            S_FETCH: begin
               if (InstrValid) begin
                  ir_q    <= InstrIn;
                  pc_q    <= pc_q + PC_ONE;
                  state_q <= S_DECODE;
               end
            end
            S_DECODE: begin
               case (op)
                  OP_J: begin
                     // Jump keeps the page bits of the already-incremented PC.
                     pc_q    <= {pc_q[PC_WIDTH-1:13], ir_q[12:0]};
                     state_q <= S_FETCH;
                  end
                  OP_HALT: state_q <= S_HALT;
                  default: state_q <= S_EXEC;
               endcase
            end
            S_EXEC: begin
               case (op)
                  OP_R, OP_ADDI: state_q <= S_WB;
                  OP_LW, OP_SW:  state_q <= S_MEM;
                  OP_BEQ, OP_BNE: begin
                     // PC already points past the branch, so the offset is relative to PC+1.
                     if (branch_taken) pc_q <= pc_q + imm_sext;
                     state_q <= S_FETCH;
                  end
                  default: state_q <= S_FETCH;
               endcase
            end
            S_MEM: begin
               if (MemReady) state_q <= (op == OP_LW) ? S_WB : S_FETCH;
            end
            S_WB:    state_q <= S_FETCH;
            S_HALT:  state_q <= S_HALT;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      InstrReq = 1'b0;
      RegDest  = 1'b0;
      ALUSrc   = 1'b0;
      MemToReg = 1'b0;
      RegWrite = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      Branch   = 1'b0;
      AluOp    = ALU_ADD;
      Halted   = 1'b0;
      case (state_q)
         S_FETCH: InstrReq = 1'b1;
         S_EXEC: begin
            case (op)
               OP_R: begin
                  RegDest = 1'b1;
                  AluOp   = ALU_FUNCT;
               end
               OP_ADDI, OP_LW, OP_SW: ALUSrc = 1'b1;
               OP_BEQ, OP_BNE: begin
                  AluOp  = ALU_SUB;
                  Branch = 1'b1;
               end
               default: ;
            endcase
         end
         S_MEM: begin
            // Address path stays selected for the whole access.
            ALUSrc   = 1'b1;
            MemRead  = (op == OP_LW);
            MemWrite = (op == OP_SW);
         end
         S_WB: begin
            RegWrite = 1'b1;
            case (op)
               OP_R: begin
                  RegDest = 1'b1;
                  AluOp   = ALU_FUNCT;
               end
               OP_ADDI: ALUSrc = 1'b1;
               OP_LW: begin
                  ALUSrc   = 1'b1;
                  MemToReg = 1'b1;
               end
               default: ;
            endcase
         end
         S_HALT:  Halted = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: directed vector table, hand-written reset
// and halt sequences, and random instruction streams against a per-instruction model.
module tb_multicycle_control_unit;

   logic        Clock = 1'b0;
   logic        Reset, Run, InstrValid, Zero, MemReady;
   logic [15:0] InstrIn;
   logic        InstrReq;
   logic [15:0] InstrAddr, Instruction;
   logic        RegDest, ALUSrc, MemToReg, RegWrite, MemRead, MemWrite, Branch, Halted;
   logic [1:0]  AluOp;

   int checks = 0;
   int errors = 0;
   logic [15:0] mpc;

   multicycle_control_unit #(.PC_WIDTH(16), .RESET_PC(16'h0000)) dut (
      .Clock(Clock), .Reset(Reset), .Run(Run),
      .InstrReq(InstrReq), .InstrAddr(InstrAddr),
      .InstrValid(InstrValid), .InstrIn(InstrIn), .Instruction(Instruction),
      .Zero(Zero), .MemReady(MemReady),
      .RegDest(RegDest), .ALUSrc(ALUSrc), .MemToReg(MemToReg), .RegWrite(RegWrite),
      .MemRead(MemRead), .MemWrite(MemWrite), .Branch(Branch),
      .AluOp(AluOp), .Halted(Halted)
   );

   always #5 Clock = ~Clock;

   typedef struct {
      logic [15:0] instr;
      int          fdly;
      int          mdly;
      logic        zero;
      logic [15:0] exp_pc;
   } vec_t;

   vec_t vec[16];

   // {InstrReq, RegDest, ALUSrc, MemToReg, RegWrite, MemRead, MemWrite, Branch, AluOp, Halted}
   function automatic logic [10:0] ctrl();
      return {InstrReq, RegDest, ALUSrc, MemToReg, RegWrite, MemRead, MemWrite,
              Branch, AluOp, Halted};
   endfunction

   function automatic logic [10:0] cv(input bit req, rd, als, m2r, rw, mr, mw, br,
                                      input bit [1:0] aop, input bit h);
      return {req, rd, als, m2r, rw, mr, mw, br, aop, h};
   endfunction

   function automatic logic [10:0] exp_exec(input logic [2:0] op);
      case (op)
         3'd0:       return cv(0,1,0,0,0,0,0,0,2'b10,0);
         3'd1, 3'd2,
         3'd3:       return cv(0,0,1,0,0,0,0,0,2'b00,0);
         3'd4, 3'd5: return cv(0,0,0,0,0,0,0,1,2'b01,0);
         default:    return '0;
      endcase
   endfunction

   function automatic logic [10:0] exp_wb(input logic [2:0] op);
      case (op)
         3'd0:    return cv(0,1,0,0,1,0,0,0,2'b10,0);
         3'd1:    return cv(0,0,1,0,1,0,0,0,2'b00,0);
         default: return cv(0,0,1,1,1,0,0,0,2'b00,0);
      endcase
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic noise();
      InstrValid = 1'($urandom);
      InstrIn    = 16'($urandom);
      Run        = 1'($urandom);
      Zero       = 1'($urandom);
      MemReady   = 1'b0;
   endtask

   task automatic do_reset(input int n);
      Reset = 1'b1;
      noise();
      repeat (n) begin
         @(negedge Clock);
         #1;
         chk("reset_ctrl", ctrl(), '0);
         chk("reset_pc", InstrAddr, 16'h0000);
         chk("reset_ir", Instruction, 16'h0000);
      end
      mpc = 16'h0000;
   endtask

   task automatic start();
      Reset = 1'b0;
      Run   = 1'b1;
      @(negedge Clock);
   endtask

   // One instruction from its first FETCH cycle; returns on the negedge of the next FETCH.
   task automatic do_instr(input logic [15:0] instr, input int fdly, input int mdly,
                           input logic z);
      logic [2:0]  op;
      logic [15:0] sx;
      op = instr[15:13];
      sx = {{9{instr[6]}}, instr[6:0]};
      for (int k = 0; k <= fdly; k++) begin
         noise();
         InstrValid = (k == fdly);
         if (k == fdly) InstrIn = instr;
         #1;
         chk("fetch_ctrl", ctrl(), cv(1,0,0,0,0,0,0,0,2'b00,0));
         chk("fetch_addr", InstrAddr, mpc);
         @(negedge Clock);
      end
      mpc = mpc + 16'd1;
      noise();
      #1;
      chk("decode_ctrl", ctrl(), '0);
      chk("decode_ir", Instruction, instr);
      @(negedge Clock);
      if (op == 3'd6) begin
         mpc = {mpc[15:13], instr[12:0]};
         return;
      end
      if (op == 3'd7) begin
         for (int k = 0; k < 6; k++) begin
            noise();
            Run = k[0];
            #1;
            chk("halt_ctrl", ctrl(), cv(0,0,0,0,0,0,0,0,2'b00,1));
            @(negedge Clock);
         end
         return;
      end
      noise();
      Zero = z;
      #1;
      chk("exec_ctrl", ctrl(), exp_exec(op));
      @(negedge Clock);
      if (op == 3'd4 || op == 3'd5) begin
         if ((op == 3'd4 && z) || (op == 3'd5 && !z)) mpc = mpc + sx;
         return;
      end
      if (op == 3'd2 || op == 3'd3) begin
         for (int k = 0; k <= mdly; k++) begin
            noise();
            MemReady = (k == mdly);
            #1;
            chk("mem_ctrl", ctrl(), (op == 3'd2) ? cv(0,0,1,0,0,1,0,0,2'b00,0)
                                                 : cv(0,0,1,0,0,0,1,0,2'b00,0));
            @(negedge Clock);
         end
         if (op == 3'd3) return;
      end
      noise();
      #1;
      chk("wb_ctrl", ctrl(), exp_wb(op));
      @(negedge Clock);
   endtask

   initial begin
      vec[0]  = '{16'h0A51, 3, 0, 1'b0, 16'h0001};
      vec[1]  = '{16'h4405, 0, 2, 1'b0, 16'h0002};
      vec[2]  = '{16'h6405, 0, 0, 1'b0, 16'h0003};
      vec[3]  = '{16'hC010, 0, 0, 1'b0, 16'h0010};
      vec[4]  = '{16'h807E, 0, 0, 1'b1, 16'h000F};
      vec[5]  = '{16'hC010, 1, 0, 1'b0, 16'h0010};
      vec[6]  = '{16'h807E, 0, 0, 1'b0, 16'h0011};
      vec[7]  = '{16'hC010, 0, 0, 1'b0, 16'h0010};
      vec[8]  = '{16'hA003, 0, 0, 1'b0, 16'h0014};
      vec[9]  = '{16'hC000, 0, 0, 1'b0, 16'h0000};
      vec[10] = '{16'h8040, 0, 0, 1'b1, 16'hFFC1};
      vec[11] = '{16'hDFFF, 0, 0, 1'b0, 16'hFFFF};
      vec[12] = '{16'h2A7F, 2, 0, 1'b0, 16'h0000};
      vec[13] = '{16'h8040, 0, 0, 1'b1, 16'hFFC1};
      vec[14] = '{16'hC000, 0, 0, 1'b0, 16'hE000};
      vec[15] = '{16'hC123, 0, 0, 1'b0, 16'hE123};

      Reset = 1'b1; Run = 1'b0; InstrValid = 1'b0; InstrIn = '0; Zero = 1'b0; MemReady = 1'b0;
      mpc = 16'h0000;

      // Reset, then start and walk the directed table.
      do_reset(2);
      start();
      for (int i = 0; i < 16; i++) begin
         do_instr(vec[i].instr, vec[i].fdly, vec[i].mdly, vec[i].zero);
         #1;
         chk("next_fetch_req", InstrReq, 1'b1);
         chk("next_fetch_addr", InstrAddr, vec[i].exp_pc);
      end
      do_instr(16'hE000, 0, 0, 1'b0);

      // Reset in the middle of a load's memory access.
      do_reset(1);
      start();
      noise(); InstrValid = 1'b1; InstrIn = 16'h4405; @(negedge Clock);
      noise(); @(negedge Clock);
      noise(); @(negedge Clock);
      noise(); #1;
      chk("midreset_memread_before", MemRead, 1'b1);
      Reset = 1'b1;
      @(negedge Clock);
      #1;
      chk("midreset_ctrl", ctrl(), '0);
      chk("midreset_pc", InstrAddr, 16'h0000);
      chk("midreset_ir", Instruction, 16'h0000);
      Reset = 1'b0; Run = 1'b0;
      repeat (2) begin
         @(negedge Clock);
         #1;
         chk("idle_hold_ctrl", ctrl(), '0);
      end
      mpc = 16'h0000;
      start();

      // Random instruction stream against the per-instruction model.
      for (int n = 0; n < 300; n++) begin
         logic [15:0] ins;
         ins = {3'($urandom_range(0, 6)), 13'($urandom)};
         do_instr(ins, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
      end
      do_instr(16'hFFFF, 1, 0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Multi-cycle sequencer for the 16-bit single-issue datapath.
- Owns the PC and the instruction register (IR).
- Fetches from instruction memory through a req/valid handshake, then decodes the 3-bit opcode.
- Drives the datapath control lines (RegDest, ALUSrc, MemToReg, RegWrite, MemRead, MemWrite, AluOp, Branch) state by state, and resolves branches and jumps from the ALU Zero flag.

Parameters:
RESET_PC, 16'h0000, PC value loaded on Reset
PC_WIDTH, 16, width of PC and instruction address

Ports:
Clock  in  1  system clock, rising edge
Reset  in  1  synchronous, active-high reset
Run  in  1  start/continue enable, sampled only in IDLE
InstrReq  out  1  instruction fetch request
InstrAddr  out  PC_WIDTH  fetch address (= PC)
InstrValid  in  1  fetch data valid this cycle
InstrIn  in  16  fetched instruction word
Instruction  out  16  latched IR, feeds datapath field decode
Zero  in  1  ALU zero flag from datapath
MemReady  in  1  data memory access complete
RegDest, ALUSrc, MemToReg, RegWrite, MemRead, MemWrite, Branch  out  1 each  datapath controls
AluOp  out  2  00=add, 01=sub, 10=use Funct
Halted  out  1  high while in HALT

Behaviour:
- Clocking: single clock, Clock; reset is synchronous and active-high (Reset).
- Reset: on Reset high at a rising edge, regardless of state (including mid-fetch or mid-memory access):
  - PC=RESET_PC, IR=0, state=IDLE.
  - All control outputs 0, InstrReq=0, Halted=0.
- Opcodes (IR[15:13]): 000 R-type, 001 ADDI, 010 LW, 011 SW, 100 BEQ, 101 BNE, 110 J, 111 HALT.
- Immediate: imm7=IR[6:0], sign-extended to 16 bits.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
- IDLE: all outputs 0. Run=1 -> FETCH.
- FETCH:
  - InstrReq=1, InstrAddr=PC; held until InstrValid=1.
  - On that edge: IR<=InstrIn, PC<=PC+1 (word-addressed, wraps 16'hFFFF->16'h0000), go to DECODE.
  - InstrValid while InstrReq=0 is ignored.
- DECODE: one cycle, all controls 0.
  - J: PC<={PC[15:13], IR[12:0]}, go to FETCH.
  - HALT: go to HALT.
  - Otherwise: go to EXEC.
- EXEC: one cycle; controls combinational from state and opcode, stable all cycle.
  - R-type: RegDest=1, ALUSrc=0, AluOp=10 -> WB.
  - ADDI: RegDest=0, ALUSrc=1, AluOp=00 -> WB.
  - LW/SW: ALUSrc=1, AluOp=00 -> MEM.
  - BEQ/BNE: ALUSrc=0, AluOp=01, Branch=1.
    - Taken if (BEQ & Zero) | (BNE & ~Zero); then PC<=PC+sext(imm7). PC already holds PC_instr+1.
    - Always -> FETCH.
- MEM: ALUSrc=1, AluOp=00 held (address stable).
  - LW: MemRead=1 held until MemReady=1, then -> WB.
  - SW: MemWrite=1 held until MemReady=1, then -> FETCH.
  - MemReady=1 on the first MEM cycle allowed (1-cycle access).
- WB: RegWrite=1 for exactly one cycle, then -> FETCH.
  - R-type: RegDest=1, AluOp=10, MemToReg=0.
  - ADDI: RegDest=0, ALUSrc=1, AluOp=00, MemToReg=0.
  - LW: RegDest=0, ALUSrc=1, AluOp=00, MemToReg=1.
- HALT: Halted=1, all other outputs 0; leaves only on Reset.
- Minimum cycles per instruction, with InstrValid and MemReady both immediate:
  - R/ADDI 4, LW 5, SW 4, BEQ/BNE 3, J 2, HALT 2.
- Run is ignored outside IDLE.
- RegWrite and MemWrite never assert in FETCH, DECODE, IDLE or HALT.

Test Plan:
- Reset/start: Reset 2 cycles, Run=1. Expect InstrReq=1 and InstrAddr=0 on the first FETCH cycle; all controls 0 during reset.
- R-type with fetch stall: IR=16'h0A51 (R-type), InstrValid delayed 3 cycles.
  - Expect InstrReq held high for 4 cycles, PC=1 after fetch.
  - EXEC: RegDest=1, AluOp=10. WB: single-cycle RegWrite=1.
- LW with slow memory: IR=16'h4405 (LW, imm=5), MemReady after 2 cycles.
  - Expect MemRead=1 for 3 cycles, then WB with MemToReg=1, RegWrite=1.
  - SW (16'h6405) with immediate MemReady: MemWrite=1 for 1 cycle, no RegWrite.
- Branches at PC=16'h0010:
  - BEQ imm=7'h7E (-2), Zero=1 -> next InstrAddr=16'h000F.
  - Same with Zero=0 -> 16'h0011.
  - BNE imm=3, Zero=0 -> 16'h0014.
- Jump and wrap:
  - J at PC=16'hE000 with IR[12:0]=13'h0123 -> next InstrAddr=16'hE123.
  - Fetch at PC=16'hFFFF -> PC wraps to 16'h0000.
- HALT and mid-op reset:
  - IR=16'hE000 (HALT) -> Halted=1, stays there with Run toggling.
  - Reset asserted while in MEM with MemRead=1 -> next cycle MemRead=0, PC=RESET_PC, state IDLE.
